// File: rtl/spmv_pkg.sv
// ============================================================================
//  Module   : spmv_pkg
//  Brief    : Shared SpMV types and constants (sequencer FSM states, FP32 zero,
//             default MAC latency, wait-counter width helper).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spmv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } seq_state_t;

    localparam logic [31:0] c_fp32_zero       = 32'h0000_0000;
    localparam int          c_default_mac_lat = 3;

    // Counter must hold MAC_LAT-2; keep at least one bit for short latencies.
    function automatic int wait_cnt_width(input int mac_lat);
        return (mac_lat > 2) ? $clog2(mac_lat) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_wait_counter.sv
// ============================================================================
//  Module   : seq_wait_counter
//  Brief    : Loadable down-counter that times the MAC WAIT interval.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_wait_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mac_row_sequencer.sv
// ============================================================================
//  Module   : mac_row_sequencer
//  Brief    : Sequences a nonzero stream through an external FP32 MAC and
//             emits one accumulated dot product per matrix row.
//             Optional: MAC_ROW_SEQUENCER_STATS_EN adds the nz_count output.
//  Revision : 1.0 - initial release (requires MAC_LAT >= 2)
// ============================================================================
`default_nettype none

module mac_row_sequencer
    import spmv_pkg::*;
#(
    parameter int MAC_LAT = c_default_mac_lat,
    parameter int ROW_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ROW_W-1:0] row_count,
    input  logic             nz_valid,
    output logic             nz_ready,
    input  logic [31:0]      nz_val,
    input  logic [31:0]      nz_vec,
    input  logic             nz_last,
    input  logic             nz_empty,
    output logic [31:0]      mac_val,
    output logic [31:0]      mac_vec,
    output logic [31:0]      mac_valsum,
    input  logic [31:0]      mac_out,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [31:0]      row_data,
    output logic [ROW_W-1:0] row_idx,
    output logic             busy,
    output logic             done
`ifdef MAC_ROW_SEQUENCER_STATS_EN
    ,
    output logic [31:0]      nz_count
`endif
);

    localparam int               c_cnt_w     = wait_cnt_width(MAC_LAT);
    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(MAC_LAT - 2);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [31:0]      r_acc;
    logic             r_load_pend;
    logic             r_last;
    logic             r_done;
    logic [ROW_W-1:0] r_row_idx;
    logic [ROW_W-1:0] r_row_count;

    logic w_start_ok;
    logic w_nz_xfer;
    logic w_issue;
    logic w_row_valid;
    logic w_row_xfer;
    logic w_last_row;
    logic w_cnt_zero;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_nz_xfer  = (r_state == ST_ISSUE) && nz_valid;
    assign w_issue    = w_nz_xfer && !nz_empty;
    assign w_row_xfer = w_row_valid && row_ready;
    assign w_last_row = (r_row_idx == (r_row_count - ROW_W'(1)));

    seq_wait_counter #(
        .CNT_W (c_cnt_w)
    ) u_wait_counter (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_issue),
        .i_load_value (c_wait_load),
        .i_dec        (r_state == ST_WAIT),
        .o_zero       (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && (row_count != '0)) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_nz_xfer) w_state_next = nz_empty ? ST_EMIT : ST_WAIT;
            end
            ST_WAIT: begin
                if (w_cnt_zero) w_state_next = r_last ? ST_EMIT : ST_ISSUE;
            end
            ST_EMIT: begin
                if (w_row_xfer) w_state_next = w_last_row ? ST_IDLE : ST_ISSUE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The first cycle after WAIT captures mac_out, so EMIT holds off row_valid then.
    always_comb begin
        nz_ready    = (r_state == ST_ISSUE);
        busy        = (r_state != ST_IDLE);
        w_row_valid = (r_state == ST_EMIT) && !r_load_pend;
        mac_val     = w_issue ? nz_val : c_fp32_zero;
        mac_vec     = w_issue ? nz_vec : c_fp32_zero;
    end

    assign row_valid  = w_row_valid;
    assign row_data   = r_acc;
    assign row_idx    = r_row_idx;
    assign mac_valsum = r_acc;
    assign done       = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= c_fp32_zero;
            r_load_pend <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_row_idx   <= '0;
            r_row_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_row_count <= row_count;
                r_row_idx   <= '0;
                r_acc       <= c_fp32_zero;
                r_load_pend <= 1'b0;
                r_done      <= (row_count == '0);
            end
            if (w_issue) begin
                r_last <= nz_last;
            end
            if ((r_state == ST_WAIT) && w_cnt_zero) begin
                r_load_pend <= 1'b1;
            end
            if (r_load_pend) begin
                r_acc       <= mac_out;
                r_load_pend <= 1'b0;
            end
            if (w_nz_xfer && nz_empty) begin
                r_acc <= c_fp32_zero;
            end
            if (w_row_xfer) begin
                r_row_idx <= r_row_idx + ROW_W'(1);
                r_acc     <= c_fp32_zero;
                r_done    <= w_last_row;
            end
        end
    end

`ifdef MAC_ROW_SEQUENCER_STATS_EN
    logic [31:0] r_nz_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nz_count <= '0;
        end else if (w_start_ok) begin
            r_nz_count <= '0;
        end else if (w_issue && (r_nz_count != '1)) begin
            r_nz_count <= r_nz_count + 32'd1;
        end
    end

    assign nz_count = r_nz_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_row_sequencer.sv
// ============================================================================
//  Module   : tb_mac_row_sequencer
//  Brief    : Self-checking bench for mac_row_sequencer with a pipelined FP32
//             MAC model and a row-level dot-product reference.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_row_sequencer;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] row_count;
    logic        nz_valid;
    logic        nz_ready;
    logic [31:0] nz_val;
    logic [31:0] nz_vec;
    logic        nz_last;
    logic        nz_empty;
    logic [31:0] mac_val;
    logic [31:0] mac_vec;
    logic [31:0] mac_valsum;
    logic [31:0] mac_out;
    logic        row_valid;
    logic        row_ready;
    logic [31:0] row_data;
    logic [15:0] row_idx;
    logic        busy;
    logic        done;
`ifdef MAC_ROW_SEQUENCER_STATS_EN
    logic [31:0] nz_count;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] last_row_data;

    real q_val[$];
    real q_vec[$];
    bit  q_last[$];
    bit  q_empty[$];

    always #5 clk = ~clk;

    mac_row_sequencer #(
        .MAC_LAT (LAT),
        .ROW_W   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .row_count  (row_count),
        .nz_valid   (nz_valid),
        .nz_ready   (nz_ready),
        .nz_val     (nz_val),
        .nz_vec     (nz_vec),
        .nz_last    (nz_last),
        .nz_empty   (nz_empty),
        .mac_val    (mac_val),
        .mac_vec    (mac_vec),
        .mac_valsum (mac_valsum),
        .mac_out    (mac_out),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .busy       (busy),
        .done       (done)
`ifdef MAC_ROW_SEQUENCER_STATS_EN
        ,
        .nz_count   (nz_count)
`endif
    );

    function automatic logic [31:0] fp32_from_real(input real x);
        real     a;
        int      e;
        logic    s;
        longint  m;
        if (x == 0.0) return 32'h0;
        s = (x < 0.0);
        a = s ? -x : x;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = longint'((a - 1.0) * 8388608.0);
        return {s, 8'(e + 127), m[22:0]};
    endfunction

    function automatic real fp32_to_real(input logic [31:0] b);
        real r;
        int  e;
        if (b[30:0] == 31'h0) return 0.0;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return b[31] ? -r : r;
    endfunction

    // MAC model: product of val/vec, valsum added one cycle later, out at +LAT.
    real p1 = 0.0;
    real pipe [0:LAT-2];
    always @(posedge clk) begin
        p1      <= fp32_to_real(mac_val) * fp32_to_real(mac_vec);
        pipe[0] <= p1 + fp32_to_real(mac_valsum);
        for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
    end
    always_comb mac_out = fp32_from_real(pipe[LAT-2]);

    function automatic real rand_half();
        return real'(int'($urandom_range(0, 16)) - 8) / 2.0;
    endfunction

    task automatic add_beat(input real v, input real x, input bit last, input bit empty);
        q_val.push_back(v);
        q_vec.push_back(x);
        q_last.push_back(last);
        q_empty.push_back(empty);
    endtask

    task automatic add_random_rows(input int rows);
        for (int r = 0; r < rows; r++) begin
            if ($urandom_range(4) == 0) begin
                add_beat(rand_half(), rand_half(), 1'b1, 1'b1);
            end else begin
                int n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) add_beat(rand_half(), rand_half(), i == n - 1, 1'b0);
            end
        end
    endtask

    // Runs one pass over the queued beats; row count comes from the queued rows.
    task automatic run_pass(input bit hold_ready, input bit poke_start);
        logic [31:0] exp_q[$];
        logic [31:0] held;
        real acc;
        int  rc, cyc, last_hs, rows_seen, stall;
        bit  fin;
        acc = 0.0;
        for (int i = 0; i < q_val.size(); i++) begin
            if (q_empty[i]) begin
                exp_q.push_back(32'h0);
                acc = 0.0;
            end else begin
                acc = acc + q_val[i] * q_vec[i];
                if (q_last[i]) begin
                    exp_q.push_back(fp32_from_real(acc));
                    acc = 0.0;
                end
            end
        end
        rc = exp_q.size();
        cyc = 0; last_hs = -100; rows_seen = 0; stall = 0; fin = 1'b0; held = '0;

        @(posedge clk); #1;
        start = 1'b1; row_count = 16'(rc); nz_valid = 1'b0; row_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && cyc < 3000) begin
            nz_valid = (q_val.size() > 0) && ($urandom_range(3) != 0);
            if (q_val.size() > 0) begin
                nz_empty = q_empty[0];
                nz_last  = q_last[0];
                nz_val   = q_empty[0] ? 32'($urandom) : fp32_from_real(q_val[0]);
                nz_vec   = q_empty[0] ? 32'($urandom) : fp32_from_real(q_vec[0]);
            end
            row_ready = (hold_ready && rows_seen == 0 && stall < 10) ? 1'b0 : ($urandom_range(2) != 0);
            if (poke_start && cyc == 3) begin
                start = 1'b1; row_count = 16'(rc + 5);
            end else begin
                start = 1'b0; row_count = 16'(rc);
            end
            @(negedge clk);
            if (nz_valid && nz_ready) begin
                n_checks++;
                if (q_empty[0]) begin
                    if (mac_val !== 32'h0 || mac_vec !== 32'h0)
                        $display("FAIL empty_mac_idle: mac_val=%h mac_vec=%h required 0/0", mac_val, mac_vec);
                end else if (mac_val !== nz_val || mac_vec !== nz_vec) begin
                    $display("FAIL mac_operands: mac_val=%h mac_vec=%h required %h/%h", mac_val, mac_vec, nz_val, nz_vec);
                end
                if ((q_empty[0] && (mac_val !== 32'h0 || mac_vec !== 32'h0)) ||
                    (!q_empty[0] && (mac_val !== nz_val || mac_vec !== nz_vec))) n_err++;
                void'(q_val.pop_front()); void'(q_vec.pop_front());
                void'(q_last.pop_front()); void'(q_empty.pop_front());
            end
            if (hold_ready && rows_seen == 0 && stall < 10 && (stall > 0 || row_valid)) begin
                if (stall == 0) held = row_data;
                n_checks++;
                if (row_valid !== 1'b1 || row_data !== held || nz_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL emit_stall: row_valid=%b row_data=%h nz_ready=%b required 1/%h/0", row_valid, row_data, nz_ready, held);
                end
                stall++;
            end
            if (row_valid && row_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_row: row_idx=%0d required no row", row_idx);
                end else begin
                    logic [31:0] e = exp_q.pop_front();
                    if (row_data !== e || row_idx !== 16'(rows_seen)) begin
                        n_err++;
                        $display("FAIL row_result: data=%h idx=%0d required %h/%0d", row_data, row_idx, e, rows_seen);
                    end
                end
                last_row_data = row_data;
                rows_seen++;
                last_hs = cyc;
            end
            if (done) begin
                n_checks++;
                if (cyc - last_hs != 1 || rows_seen != rc || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_timing: delay=%0d rows=%0d busy=%b required 1/%0d/0", cyc - last_hs, rows_seen, busy, rc);
                end
                fin = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        nz_valid = 1'b0; row_ready = 1'b0; start = 1'b0;
        if (!fin) begin
            n_checks++; n_err++;
            $display("FAIL pass_timeout: rows=%0d required %0d with done", rows_seen, rc);
        end
        q_val.delete(); q_vec.delete(); q_last.delete(); q_empty.delete();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, nz_ready, row_valid, done} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: busy/nz_ready/row_valid/done=%b required 0000", {busy, nz_ready, row_valid, done});
        end
        n_checks++;
        if (mac_val !== 0 || mac_vec !== 0 || mac_valsum !== 0) begin
            n_err++;
            $display("FAIL reset_mac: %h %h %h required zeros", mac_val, mac_vec, mac_valsum);
        end
        n_checks++;
        if (row_data !== 0 || row_idx !== 0) begin
            n_err++;
            $display("FAIL reset_row: data=%h idx=%0d required 0/0", row_data, row_idx);
        end
    endtask

    task automatic test_directed_row();
        add_beat(2.0, 3.0, 1'b0, 1'b0);
        add_beat(4.0, 0.5, 1'b1, 1'b0);
        run_pass(1'b0, 1'b0);
        n_checks++;
        if (last_row_data !== 32'h4100_0000) begin
            n_err++;
            $display("FAIL directed_row: row_data=%h required 41000000", last_row_data);
        end
    endtask

    task automatic test_empty_middle();
        add_beat(1.5, 2.0, 1'b0, 1'b0);
        add_beat(-3.0, 0.5, 1'b1, 1'b0);
        add_beat(7.0, 7.0, 1'b1, 1'b1);
        add_beat(2.5, -2.0, 1'b1, 1'b0);
        run_pass(1'b0, 1'b0);
    endtask

    task automatic test_random_passes();
        for (int p = 0; p < 4; p++) begin
            add_random_rows($urandom_range(1, 5));
            run_pass(1'b0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        add_beat(3.0, 1.5, 1'b1, 1'b0);
        add_random_rows(1);
        run_pass(1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        add_random_rows(3);
        run_pass(1'b0, 1'b1);
        add_random_rows(2);
        run_pass(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_row();
        int bad = 0;
        @(posedge clk); #1;
        start = 1'b1; row_count = 16'd1; nz_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; nz_valid = 1'b1; nz_empty = 1'b0; nz_last = 1'b0;
        nz_val = fp32_from_real(2.0); nz_vec = fp32_from_real(3.0);
        @(posedge clk); #1;
        nz_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, nz_ready, row_valid, done} !== 4'b0 || mac_val !== 0 || mac_vec !== 0 ||
            mac_valsum !== 0 || row_data !== 0 || row_idx !== 0) begin
            n_err++;
            $display("FAIL midrow_reset: busy=%b ready=%b rv=%b done=%b valsum=%h data=%h required all 0",
                     busy, nz_ready, row_valid, done, mac_valsum, row_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nz_valid = 1'b1; nz_last = 1'b1; row_ready = 1'b1;
            nz_val = 32'($urandom); nz_vec = 32'($urandom);
            @(negedge clk);
            if (row_valid || nz_ready || done) bad++;
            @(posedge clk); #1;
        end
        nz_valid = 1'b0; row_ready = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: active cycles=%0d required 0", bad);
        end
        add_beat(-1.5, 4.0, 1'b0, 1'b0);
        add_beat(0.5, 0.5, 1'b1, 1'b0);
        run_pass(1'b0, 1'b0);
    endtask

    task automatic test_zero_rows();
        int bad = 0;
        @(posedge clk); #1;
        start = 1'b1; row_count = 16'd0;
        @(negedge clk);
        if (done || nz_ready || row_valid) bad++;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || bad != 0 || nz_ready !== 1'b0 || row_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_rows: done=%b early=%0d nz_ready=%b row_valid=%b busy=%b required 1/0/0/0/0",
                     done, bad, nz_ready, row_valid, busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL zero_rows_pulse: done=%b required 0", done);
        end
    endtask

`ifdef MAC_ROW_SEQUENCER_STATS_EN
    task automatic test_stats();
        add_beat(1.0, 2.0, 1'b0, 1'b0);
        add_beat(3.0, 1.0, 1'b0, 1'b0);
        add_beat(0.5, 2.0, 1'b1, 1'b0);
        add_beat(9.0, 9.0, 1'b1, 1'b1);
        add_beat(-2.0, 2.0, 1'b0, 1'b0);
        add_beat(4.0, 0.5, 1'b1, 1'b0);
        run_pass(1'b0, 1'b0);
        n_checks++;
        if (nz_count !== 32'd5) begin
            n_err++;
            $display("FAIL nz_count: got %0d required 5", nz_count);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; row_count = '0;
        nz_valid = 1'b0; nz_val = '0; nz_vec = '0; nz_last = 1'b0; nz_empty = 1'b0;
        row_ready = 1'b0; last_row_data = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_directed_row();
        test_empty_middle();
        test_random_passes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_row();
        test_zero_rows();
`ifdef MAC_ROW_SEQUENCER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mac_row_sequencer.md
MAC_ROW_SEQUENCER -- requirements
Module: mac_row_sequencer

Interface
REQ-001 SHALL have parameter MAC_LAT, default 3, meaning the MAC input-to-out latency in cycles, from val/vec presentation to out readable.
REQ-002 SHALL have parameter ROW_W, default 16, meaning the width of the row counter and row index.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that begins a matrix pass; ignored unless in IDLE.
REQ-006 row_count  in  ROW_W  number of rows in the pass; sampled on start.
REQ-007 nz_valid / nz_ready  in / out  1 / 1  nonzero stream handshake; a transfer occurs when both are high.
REQ-008 nz_val  in  32  FP32 matrix value.
REQ-009 nz_vec  in  32  FP32 gathered vector element.
REQ-010 nz_last  in  1  marks the last nonzero of the current row.
REQ-011 nz_empty  in  1  marks an empty row; nz_val and nz_vec are ignored on this beat.
REQ-012 mac_val, mac_vec  out  32 each  MAC multiplicand operands.
REQ-013 mac_valsum  out  32  MAC addend, equal to the running row accumulator.
REQ-014 mac_out  in  32  MAC result.
REQ-015 row_valid / row_ready  out / in  1 / 1  row result handshake.
REQ-016 row_data  out  32  FP32 row dot product.
REQ-017 row_idx  out  ROW_W  index of the row being emitted.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse when the pass completes.

Function
REQ-020 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> (ISSUE | EMIT) -> (ISSUE | IDLE); an empty row goes ISSUE -> EMIT directly.
REQ-021 SHALL assert nz_ready only in ISSUE.
REQ-022 On a non-empty ISSUE transfer, SHALL drive mac_val=nz_val and mac_vec=nz_vec in that same cycle (t); otherwise it SHALL drive both to 0.
REQ-023 SHALL hold mac_valsum equal to acc continuously; acc SHALL be stable during cycle t+1.
REQ-024 WAIT SHALL last MAC_LAT-1 cycles (t+1 to t+MAC_LAT-1); in cycle t+MAC_LAT the block SHALL load acc <= mac_out.
REQ-025 After the load, SHALL go to ISSUE if the captured beat had nz_last=0, else to EMIT; the issue interval is therefore MAC_LAT cycles.
REQ-026 The first product of a row SHALL use acc=32'h0000_0000.
REQ-027 On an nz_empty transfer, SHALL set acc=0 and go to EMIT without issuing to the MAC.
REQ-028 In EMIT, SHALL hold row_valid=1, row_data=acc and row_idx=current row, stable until row_ready.
REQ-029 On the row handshake, SHALL increment the row index and clear acc; if the row index equals row_count-1, SHALL pulse done and go to IDLE, else go to ISSUE.
REQ-030 With row_count=0, start SHALL produce done one cycle later with no nz_ready and no row_valid.
REQ-031 A start pulse while busy SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE, set acc, the row index, all mac_* outputs, row_data and row_idx to 0, and deassert nz_ready, row_valid, busy and done.
REQ-033 Reset mid-row SHALL discard in-flight MAC results; no row_valid SHALL follow until a new start.

Configuration
REQ-034 With MAC_ROW_SEQUENCER_STATS_EN defined, SHALL add output nz_count (32 bits), counting nonzero transfers since start, cleared on start and reset, and saturating at all-ones.
REQ-035 Without MAC_ROW_SEQUENCER_STATS_EN, SHALL have no nz_count port or counter logic.

Structure
REQ-036 The FSM state enum, FP32 zero constant and default MAC_LAT SHALL live in shared package spmv_pkg.
REQ-037 SHALL contain one natural sub-module, seq_wait_counter, a loadable down-counter for the WAIT interval; the MAC SHALL NOT be instantiated inside this block.

Verification
REQ-038 Bench SHALL model the MAC as a MAC_LAT-stage pipe with exact FP32 arithmetic and valsum sampled one cycle after val/vec.
REQ-039 Row of nz (2.0,3.0),(4.0,0.5) with row_count=1 -> row_data=32'h4100_0000 (8.0), row_idx=0, done one cycle after the handshake.
REQ-040 Three rows, the middle one nz_empty -> row_data 0x0 for row 1, row indices 0,1,2 in order.
REQ-041 row_ready held low 10 cycles in EMIT -> row_valid/row_data stable, nz_ready=0 throughout.
REQ-042 Reset asserted in WAIT of row 0 -> all outputs 0 the next cycle; a new start with row_count=1 gives a correct result.
REQ-043 row_count=0 -> done exactly one cycle after start; a start during busy -> no effect; with STATS_EN, 5 nonzeros give nz_count=5.
